// File: rtl/comparator_8bit_using_1bit_pkg.sv
// Shared types and constants for the cascaded magnitude comparator.
// Result packing: one bit each for greater, equal and lesser.
package comparator_8bit_using_1bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam int CMP_LT_BIT = 0;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_GT_BIT = 2;

  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_NONE = 3'b000;

  function automatic cmp_res_t pack_flags(
    input logic gt,
    input logic eq,
    input logic lt
  );
    cmp_res_t r;
    r = CMP_NONE;
    r[CMP_GT_BIT] = gt;
    r[CMP_EQ_BIT] = eq;
    r[CMP_LT_BIT] = lt;
    return r;
  endfunction

endpackage

// File: rtl/comparator_8bit_using_1bit_bit.sv
// One slice of the comparator chain.
// Carries the decision from the more significant bits downward.
module comparator_1bit (
  input  logic a,
  input  logic b,
  input  logic gt_in,
  input  logic eq_in,
  input  logic lt_in,
  output logic gt_out,
  output logic eq_out,
  output logic lt_out
);

  logic g_i;
  logic e_i;
  logic l_i;

  // Local bit relation, then merge with the upstream decision
  always_comb begin
    g_i    = a & ~b;
    e_i    = ~(a ^ b);
    l_i    = ~a & b;
    gt_out = gt_in | (eq_in & g_i);
    lt_out = lt_in | (eq_in & l_i);
    eq_out = eq_in & e_i;
  end

endmodule

// File: rtl/comparator_8bit_using_1bit.sv
// Unsigned WIDTH-bit comparator built from a chain of 1-bit slices.
// Flags are registered; result appears one cycle after in_valid.
module comparator_8bit_using_1bit
  import comparator_8bit_using_1bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             A_greater_B,
  output logic             A_equal_B,
  output logic             A_lesser_B
);

  // Node i+1 feeds slice i; node WIDTH is the MSB-side seed
  logic [WIDTH:0] gt_c;
  logic [WIDTH:0] eq_c;
  logic [WIDTH:0] lt_c;

  assign gt_c[WIDTH] = 1'b0;
  assign eq_c[WIDTH] = 1'b1;
  assign lt_c[WIDTH] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    comparator_1bit u_bit (
      .a      (A[i]),
      .b      (B[i]),
      .gt_in  (gt_c[i+1]),
      .eq_in  (eq_c[i+1]),
      .lt_in  (lt_c[i+1]),
      .gt_out (gt_c[i]),
      .eq_out (eq_c[i]),
      .lt_out (lt_c[i])
    );
  end

  cmp_res_t res_d;
  cmp_res_t res_q;
  logic     vld_q;

  // Pack the final cascade outputs
  always_comb begin
    res_d = pack_flags(gt_c[0], eq_c[0], lt_c[0]);
  end

  // Capture on in_valid, hold flags otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= CMP_NONE;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid   = vld_q;
  assign A_greater_B = res_q[CMP_GT_BIT];
  assign A_equal_B   = res_q[CMP_EQ_BIT];
  assign A_lesser_B  = res_q[CMP_LT_BIT];

endmodule

// File: tb/tb_comparator_8bit_using_1bit.sv
// Bench for the cascaded comparator against an arithmetic model.
// Directed, exhaustive and random phases.
module tb_comparator_8bit_using_1bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic       A_greater_B;
  logic       A_equal_B;
  logic       A_lesser_B;

  int total;
  int bad;

  logic  exp_ov;
  logic  exp_g;
  logic  exp_e;
  logic  exp_l;
  string cur_tag;

  comparator_8bit_using_1bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .A_greater_B (A_greater_B),
    .A_equal_B   (A_equal_B),
    .A_lesser_B  (A_lesser_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string what, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s %s observed=%b expected=%b",
             cur_tag, what, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("out_valid", out_valid, exp_ov);
    chk("greater", A_greater_B, exp_g);
    chk("equal", A_equal_B, exp_e);
    chk("lesser", A_lesser_B, exp_l);
    if (exp_ov) begin
      chk("onehot",
          ($countones({A_greater_B, A_equal_B, A_lesser_B}) == 1), 1'b1);
    end
  endtask

  task automatic model_reset();
    exp_ov = 1'b0;
    exp_g  = 1'b0;
    exp_e  = 1'b0;
    exp_l  = 1'b0;
  endtask

  // Drive one pair, clock once, then check against the model
  task automatic apply(input logic [7:0] a, input logic [7:0] b,
                       input logic v, input string tag);
    int ai;
    int bi;
    A        = a;
    B        = b;
    in_valid = v;
    cur_tag  = $sformatf("%s a=%02h b=%02h v=%b", tag, a, b, v);
    @(posedge clk);
    #1;
    ai = int'(a);
    bi = int'(b);
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_ov = v;
      if (v) begin
        exp_g = (ai > bi);
        exp_e = (ai == bi);
        exp_l = (ai < bi);
      end
    end
    chk_all();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 8'($urandom);
    B        = 8'($urandom);
    cur_tag  = "init";
    model_reset();

    apply(8'($urandom), 8'($urandom), 1'b1, "in_reset");
    apply(8'($urandom), 8'($urandom), 1'b1, "in_reset");

    #2 rst_n = 1'b1;
    apply(8'b11001010, 8'b10101010, 1'b1, "first");

    apply(8'b00011000, 8'b00110000, 1'b1, "lt_vec");
    apply(8'b11110000, 8'b11110000, 1'b1, "eq_vec");
    apply(8'h00, 8'h00, 1'b1, "zeros");
    apply(8'hFF, 8'h01, 1'b1, "ff_01");
    apply(8'h00, 8'hFF, 1'b0, "hold");
    apply(8'h12, 8'h34, 1'b0, "hold2");
    apply(8'h01, 8'hFF, 1'b1, "01_ff");
    apply(8'h80, 8'h80, 1'b1, "80_80");
    apply(8'h80, 8'h7F, 1'b1, "unsigned");
    apply(8'h00, 8'h01, 1'b1, "lsb");
    apply(8'hFF, 8'h00, 1'b1, "ones_zeros");

    // Asynchronous reset between edges
    apply(8'h55, 8'h54, 1'b1, "pre_rst");
    in_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    cur_tag = "async_rst";
    model_reset();
    chk_all();
    #2 rst_n = 1'b1;
    apply(8'h10, 8'h20, 1'b1, "post_rst");
    apply(8'h20, 8'h20, 1'b1, "post_rst2");

    for (int i = 0; i < 65536; i++) begin
      apply(8'(i >> 8), 8'(i), 1'b1, "sweep");
    end

    for (int i = 0; i < 2000; i++) begin
      apply(8'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
